combo_lock_core: RTL
====================

// Module: combo_lock_core
// PURPOSE
//  Parametrised combination-lock core with FSM and datapath in one block.
//  Takes DIGITS keypad digits and holds an open window on a match.
//  Enforces a failed-attempt limit with a timed lockout.
//  Accepting the reversed code opens the lock and raises a silent duress alarm.
//  Sits between the debounced keypad and the door/LED drivers; reprogramming is only allowed while open.
// PARAMETERS
//  DIGITS         4        digits per code (>=2)
//  DIGIT_W        4        bits per digit
//  DEFAULT_CODE   16'h1234 code loaded on Reset, width DIGITS*DIGIT_W, first digit in MS slot
//  MAX_TRIES      3        consecutive failures that trigger lockout (>=1)
//  LOCKOUT_CYCLES 1000     lockout duration in Clock cycles (>=1)
//  OPEN_CYCLES    500      Unlocked window in Clock cycles (>=1)
// PORTS
//  Clock      in   1                 system clock, all logic on rising edge
//  Reset      in   1                 synchronous, active-high
//  Number     in   DIGIT_W           digit value, sampled when Validate=1
//  Validate   in   1                 one-cycle strobe: shift Number into entry register
//  Enter      in   1                 one-cycle strobe: submit entry
//  Clear      in   1                 abort current entry, back to IDLE, no failure counted
//  Program    in   1                 request code change; honoured only in OPEN
//  Unlocked   out  1                 high throughout OPEN and PROG
//  Alarm      out  1                 sticky duress flag
//  LockedOut  out  1                 high throughout LOCKOUT
//  Error      out  1                 one-cycle pulse on failed or short submit
//  ProgDone   out  1                 one-cycle pulse when new code stored
//  Fails      out  $clog2(MAX_TRIES+1)  consecutive failure count
//  State      out  3                 IDLE=0 ENTRY=1 CHECK=2 OPEN=3 PROG=4 LOCKOUT=5
// BEHAVIOUR
//  Registers
//   - A: entry register. B: stored code. CNT: digit count, saturating at DIGITS.
//  Reset
//   - B=DEFAULT_CODE; A=0; CNT=0; Fails=0; State=IDLE.
//   - All outputs 0, Alarm included.
//   - Reset wins over every input in any state, including mid-entry, PROG and LOCKOUT.
//  Digit shift
//   - A <= {A[(DIGITS-1)*DIGIT_W-1:0], Number}.
//   - Beyond DIGITS digits the oldest digit is dropped and CNT stays DIGITS.
//  Input priority in one cycle: Clear > Enter > Validate.
//   - A Validate in the same cycle as Enter or Clear is ignored.
//  IDLE
//   - A=0, CNT=0.
//   - Validate: shift, CNT=1, go to ENTRY.
//   - Enter or Clear: no effect.
//  ENTRY
//   - Validate: shift.
//   - Clear: go to IDLE.
//   - Enter with CNT==DIGITS: go to CHECK.
//   - Enter with CNT<DIGITS: counts as a failure (same path as a mismatch in CHECK).
//  CHECK (1 cycle; inputs ignored)
//   - A==B: go to OPEN; Fails=0; Alarm cleared.
//   - else A==digit-reverse(B): go to OPEN; Fails=0; Alarm<=1.
//     Exact match wins, so a palindrome code never alarms.
//   - else (mismatch): Error pulse; Fails+1.
//     If Fails reaches MAX_TRIES, go to LOCKOUT; otherwise go to IDLE.
//   - Latency: Enter at cycle t -> CHECK at t+1 -> Unlocked=1 from t+2.
//  OPEN
//   - Unlocked=1 for exactly OPEN_CYCLES cycles, then go to IDLE.
//   - Clear: go to IDLE at once.
//   - Program: go to PROG with A=0, CNT=0; the OPEN timer is discarded.
//  PROG
//   - Unlocked=1; no timeout.
//   - Validate: shift.
//   - Enter with CNT==DIGITS: B<=A, ProgDone pulse, go to IDLE.
//   - Enter with CNT<DIGITS: Error pulse, B unchanged, go to IDLE. Fails not incremented.
//   - Clear: go to IDLE, B unchanged.
//  LOCKOUT
//   - LockedOut=1; all inputs ignored for LOCKOUT_CYCLES cycles.
//   - Then go to IDLE with Fails=0.
//  Timers
//   - Single shared down-counter, width $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1).
//   - Loaded on state entry; no wrap-around.
// TESTING
//  1 Reset; enter digits 1,2,3,4 then Enter -> Unlocked=1 two cycles after Enter,
//    held 500 cycles, then State=IDLE.
//  2 Enter 4,3,2,1 -> Unlocked=1 and Alarm=1; Alarm stays set after timeout;
//    exact code 1234 clears it; Reset clears it.
//  3 Three wrong codes (e.g. 5555) -> Error pulses, Fails=1,2, then LockedOut=1 for 1000 cycles;
//    Validate/Enter ignored during lockout; Fails=0 afterwards.
//  4 Open, Program, enter 9,8,7,6, Enter -> ProgDone; 1234 now fails; 9876 opens.
//  5 Enter 1,2,3 then Enter -> Error, Fails=1. Enter 7,1,2,3,4 then Enter -> opens (oldest digit dropped).
//  6 Validate and Enter in the same cycle are ignored by shift.
//    Clear mid-entry -> IDLE, Fails unchanged.
//    Reset during PROG -> B=1234.

Source files
------------

// File: rtl/combo_lock_core_if.sv
// Keypad-side and indicator-side signals of the combination-lock core.
`timescale 1ns/1ps
interface combo_lock_core_if #(
  parameter int DIGIT_W = 4,
  parameter int FAIL_W  = 2
);
  logic [DIGIT_W-1:0] Number;
  logic               Validate;
  logic               Enter;
  logic               Clear;
  logic               Program;
  logic               Unlocked;
  logic               Alarm;
  logic               LockedOut;
  logic               Error;
  logic               ProgDone;
  logic [FAIL_W-1:0]  Fails;
  logic [2:0]         State;

  modport master (
    output Number, Validate, Enter, Clear, Program,
    input  Unlocked, Alarm, LockedOut, Error, ProgDone, Fails, State
  );

  modport slave (
    input  Number, Validate, Enter, Clear, Program,
    output Unlocked, Alarm, LockedOut, Error, ProgDone, Fails, State
  );
endinterface

// File: rtl/combo_lock_core.sv
// Combination-lock core: digit entry, code check with duress detection,
// failure lockout, timed open window and reprogramming while open.
`timescale 1ns/1ps
module combo_lock_core #(
  parameter int                           DIGITS         = 4,
  parameter int                           DIGIT_W        = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]    DEFAULT_CODE   = 16'h1234,
  parameter int                           MAX_TRIES      = 3,
  parameter int                           LOCKOUT_CYCLES = 1000,
  parameter int                           OPEN_CYCLES    = 500
) (
  input logic              Clock,
  input logic              Reset,
  combo_lock_core_if.slave bus
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int TMAX   = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W  = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_OPEN    = 3'd3,
    ST_PROG    = 3'd4,
    ST_LOCKOUT = 3'd5
  } state_t;

  function automatic logic [CODE_W-1:0] digit_rev(input logic [CODE_W-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*DIGIT_W +: DIGIT_W] = v[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
    end
    return r;
  endfunction

  state_t              state_r, state_nx_s;
  logic [CODE_W-1:0]   entry_r, entry_q_s, entry_nx_s;
  logic [CODE_W-1:0]   code_r, code_nx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_q_s, cnt_nx_s;
  logic [FAIL_W-1:0]   fails_r, fails_nx_s;
  logic [TMR_W-1:0]    timer_r, timer_nx_s;
  logic                alarm_r, alarm_nx_s;
  logic                error_r, error_nx_s;
  logic                prog_done_r, prog_done_nx_s;
  logic                unlocked_r, locked_out_r;

  logic [CODE_W-1:0]   shift_val_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic                cnt_full_s;
  logic                clr_entry_s;

  assign shift_val_s = {entry_r[CODE_W-DIGIT_W-1:0], bus.Number};
  assign cnt_full_s  = (cnt_r == CNT_W'(DIGITS));
  assign cnt_inc_s   = cnt_full_s ? cnt_r : cnt_r + CNT_W'(1);

  // Next-state, datapath and pulse decode; Clear > Enter > Validate.
  always_comb begin
    state_nx_s     = state_r;
    entry_q_s      = entry_r;
    cnt_q_s        = cnt_r;
    code_nx_s      = code_r;
    fails_nx_s     = fails_r;
    timer_nx_s     = timer_r;
    alarm_nx_s     = alarm_r;
    error_nx_s     = 1'b0;
    prog_done_nx_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.Validate && !bus.Enter && !bus.Clear) begin
          entry_q_s  = {{(CODE_W-DIGIT_W){1'b0}}, bus.Number};
          cnt_q_s    = CNT_W'(1);
          state_nx_s = ST_ENTRY;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ENTRY: begin
        if (bus.Clear) begin
          state_nx_s = ST_IDLE;
        end else if (bus.Enter) begin
          // short entries also go through CHECK so every failure shares one path
          state_nx_s = ST_CHECK;
        end else if (bus.Validate) begin
          entry_q_s = shift_val_s;
          cnt_q_s   = cnt_inc_s;
        end else begin
          state_nx_s = ST_ENTRY;
        end
      end
      ST_CHECK: begin
        if (cnt_full_s && (entry_r == code_r)) begin
          state_nx_s = ST_OPEN;
          fails_nx_s = '0;
          alarm_nx_s = 1'b0;
          timer_nx_s = TMR_W'(OPEN_CYCLES - 1);
        end else if (cnt_full_s && (entry_r == digit_rev(code_r))) begin
          state_nx_s = ST_OPEN;
          fails_nx_s = '0;
          alarm_nx_s = 1'b1;
          timer_nx_s = TMR_W'(OPEN_CYCLES - 1);
        end else begin
          error_nx_s = 1'b1;
          fails_nx_s = fails_r + FAIL_W'(1);
          if (fails_r == FAIL_W'(MAX_TRIES - 1)) begin
            state_nx_s = ST_LOCKOUT;
            timer_nx_s = TMR_W'(LOCKOUT_CYCLES - 1);
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
      end
      ST_OPEN: begin
        if (bus.Clear) begin
          state_nx_s = ST_IDLE;
        end else if (bus.Program) begin
          state_nx_s = ST_PROG;
        end else if (timer_r == TMR_W'(0)) begin
          state_nx_s = ST_IDLE;
        end else begin
          timer_nx_s = timer_r - TMR_W'(1);
        end
      end
      ST_PROG: begin
        if (bus.Clear) begin
          state_nx_s = ST_IDLE;
        end else if (bus.Enter) begin
          state_nx_s = ST_IDLE;
          if (cnt_full_s) begin
            code_nx_s      = entry_r;
            prog_done_nx_s = 1'b1;
          end else begin
            error_nx_s = 1'b1;
          end
        end else if (bus.Validate) begin
          entry_q_s = shift_val_s;
          cnt_q_s   = cnt_inc_s;
        end else begin
          state_nx_s = ST_PROG;
        end
      end
      ST_LOCKOUT: begin
        if (timer_r == TMR_W'(0)) begin
          state_nx_s = ST_IDLE;
          fails_nx_s = '0;
        end else begin
          timer_nx_s = timer_r - TMR_W'(1);
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Entry register is wiped when returning to IDLE or freshly entering OPEN/PROG.
  always_comb begin
    clr_entry_s = (state_nx_s == ST_IDLE) ||
                  ((state_nx_s != state_r) && ((state_nx_s == ST_OPEN) || (state_nx_s == ST_PROG)));
    entry_nx_s  = clr_entry_s ? '0 : entry_q_s;
    cnt_nx_s    = clr_entry_s ? '0 : cnt_q_s;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r      <= ST_IDLE;
      entry_r      <= '0;
      code_r       <= DEFAULT_CODE;
      cnt_r        <= '0;
      fails_r      <= '0;
      timer_r      <= '0;
      alarm_r      <= 1'b0;
      error_r      <= 1'b0;
      prog_done_r  <= 1'b0;
      unlocked_r   <= 1'b0;
      locked_out_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      entry_r      <= entry_nx_s;
      code_r       <= code_nx_s;
      cnt_r        <= cnt_nx_s;
      fails_r      <= fails_nx_s;
      timer_r      <= timer_nx_s;
      alarm_r      <= alarm_nx_s;
      error_r      <= error_nx_s;
      prog_done_r  <= prog_done_nx_s;
      unlocked_r   <= (state_nx_s == ST_OPEN) || (state_nx_s == ST_PROG);
      locked_out_r <= (state_nx_s == ST_LOCKOUT);
    end
  end

  assign bus.Unlocked  = unlocked_r;
  assign bus.Alarm     = alarm_r;
  assign bus.LockedOut = locked_out_r;
  assign bus.Error     = error_r;
  assign bus.ProgDone  = prog_done_r;
  assign bus.Fails     = fails_r;
  assign bus.State     = state_r;

endmodule
